// File: rtl/ascon_perm_sequencer.sv
// Cycle-level sequencer for the serial ASCON state register: one load, then n rounds of masked S-box pass + linear pass.
// Optional `SEQ_STALL_EN adds a stall input that freezes the shift passes while masking randomness is unavailable.
module ascon_perm_sequencer #(
  parameter int PAR                = 1,
  parameter int d                  = 2,
  parameter int WORD_SIZE          = 64,
  parameter int SHIFT_PAR_D_PLUS_1 = (((d + 1) * PAR) < WORD_SIZE) ? ((d + 1) * PAR) : WORD_SIZE,
  parameter int C_SB               = (WORD_SIZE + SHIFT_PAR_D_PLUS_1 - 1) / SHIFT_PAR_D_PLUS_1,
  parameter int C_LIN              = (WORD_SIZE + PAR - 1) / PAR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] n_rounds,
`ifdef SEQ_STALL_EN
  input  logic       stall,
`endif
  output logic       write_en,
  output logic       shift_en,
  output logic       shift_type,
  output logic       last_cycle,
  output logic [3:0] rc_idx,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD  | parallel load of the state register
  // SBOX  | masked substitution pass of the current round
  // LIN   | linear pass of the current round
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SBOX, S_LIN, S_DONE} state_t;

  state_t     state_q, state_n;
  logic [3:0] rounds_q, rounds_n;
  logic [3:0] round_q, round_n;
  logic [6:0] cyc_q, cyc_n;
  logic       hold;
  logic       cyc_last;

`ifdef SEQ_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  // rounds_q resets to 12 so rc_idx decodes to 0 out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rounds_q <= 4'd12;
      round_q  <= 4'd0;
      cyc_q    <= 7'd0;
    end else begin
      state_q  <= state_n;
      rounds_q <= rounds_n;
      round_q  <= round_n;
      cyc_q    <= cyc_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    rounds_n   = rounds_q;
    round_n    = round_q;
    cyc_n      = cyc_q;
    write_en   = 1'b0;
    shift_en   = 1'b0;
    shift_type = 1'b0;
    last_cycle = 1'b0;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    rc_idx     = 4'd12 - rounds_q + round_q;
    cyc_last   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rounds_n = (n_rounds > 4'd12) ? 4'd12 : n_rounds;
          round_n  = 4'd0;
          cyc_n    = 7'd0;
          state_n  = S_LOAD;
        end
      end
      S_LOAD: begin
        write_en = 1'b1;
        state_n  = (rounds_q != 4'd0) ? S_SBOX : S_DONE;
      end
      S_SBOX: begin
        cyc_last   = (cyc_q == 7'(C_SB - 1));
        shift_en   = !hold;
        last_cycle = !hold && cyc_last;
        if (!hold) begin
          if (cyc_last) begin
            cyc_n   = 7'd0;
            state_n = S_LIN;
          end else begin
            cyc_n = cyc_q + 7'd1;
          end
        end
      end
      S_LIN: begin
        cyc_last   = (cyc_q == 7'(C_LIN - 1));
        shift_en   = !hold;
        shift_type = 1'b1;
        last_cycle = !hold && cyc_last;
        if (!hold) begin
          if (cyc_last) begin
            cyc_n   = 7'd0;
            round_n = round_q + 4'd1;
            state_n = ((round_q + 4'd1) == rounds_q) ? S_DONE : S_SBOX;
          end else begin
            cyc_n = cyc_q + 7'd1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Randomized bench for ascon_perm_sequencer: every cycle of each run is compared to a timeline model
// derived from round/pass lengths (load at cycle 1, rounds of C_SB + C_LIN cycles, done after the last round).
module tb_ascon_perm_sequencer;
  localparam int C_SB  = 22;
  localparam int C_LIN = 64;
  localparam int T     = C_SB + C_LIN;
`ifdef SEQ_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, stall;
  logic [3:0] n_rounds;
  logic       write_en, shift_en, shift_type, last_cycle, busy, done;
  logic [3:0] rc_idx;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  ascon_perm_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_rounds   (n_rounds),
`ifdef SEQ_STALL_EN
    .stall      (stall),
`endif
    .write_en   (write_en),
    .shift_en   (shift_en),
    .shift_type (shift_type),
    .last_cycle (last_cycle),
    .rc_idx     (rc_idx),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {write_en, shift_en, shift_type, last_cycle, busy, done, rc_idx}
  function automatic logic [9:0] outs();
    return {write_en, shift_en, shift_type, last_cycle, busy, done, rc_idx};
  endfunction

  // Expected outputs at progress position e (1 = load) for n rounds; st = stalled this cycle.
  function automatic logic [9:0] exp_vec(input int e, input int n, input bit st);
    int j, r, p;
    logic [9:0] v;
    v = '0;
    if (e == 1) begin
      v = {6'b100010, 4'(12 - n)};
    end else if (e >= 2 && e < 2 + n * T) begin
      j = e - 2;
      r = j / T;
      p = j % T;
      v = {1'b0, !st, (p >= C_SB), (!st && (p == C_SB - 1 || p == T - 1)), 1'b1, 1'b0, 4'(12 - n + r)};
    end else if (e == 2 + n * T) begin
      v = {6'b000011, 4'd12};
    end
    return v;
  endfunction

  // Starts in an IDLE cycle; returns at the start of the IDLE cycle after DONE (or after an abort).
  task automatic run_perm(input int n_req, input bit pulse, input int stall_at, input int stall_len,
                          input int stall_pct, input int abort_at);
    int n, e, k, stalls, dones, writes, done_k;
    bit st, seen;
    n = (n_req > 12) ? 12 : n_req;
    e = 0; k = 0; stalls = 0; dones = 0; writes = 0; done_k = -1; seen = 1'b0;
    start = 1'b1;
    n_rounds = 4'(n_req);
    stall = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    k = 1; e = 1;
    start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
    n_rounds = 4'($urandom_range(0, 15));
    forever begin
      @(negedge clk);
      if (abort_at != 0 && k == abort_at + 1) begin
        check("abort_outs", 32'(outs()), 32'd0);
        rst = 1'b0;
        break;
      end
      st = STALL_EN && stall && e >= 2 && e < 2 + n * T;
      check("outs", 32'(outs()), 32'(exp_vec(e, n, st)));
      if (write_en) writes++;
      if (done) begin dones++; done_k = k; end
      if (e == 2 + n * T) break;
      if (st) stalls++; else e++;
      if (k > 3000) begin
        check("timeout_cycle", 32'(k), 32'd0);
        break;
      end
      @(posedge clk); #1;
      k++;
      start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      n_rounds = 4'($urandom_range(0, 15));
      stall = STALL_EN && ((k >= stall_at && k < stall_at + stall_len) || ($urandom_range(0, 99) < stall_pct));
      rst = (abort_at != 0 && k == abort_at);
    end
    @(posedge clk); #1;
    start = 1'b0; stall = 1'b0; rst = 1'b0;
    if (abort_at != 0) begin
      repeat (40) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end else begin
      check("done_cycle", 32'(done_k), 32'(2 + n * T + stalls));
      check("done_count", 32'(dones), 32'd1);
      check("write_count", 32'(writes), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; n_rounds = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outs", 32'(outs()), 32'd0);
    @(posedge clk); #1;

    run_perm(12, 1'b0, 0, 0, 0, 0);
    run_perm(6,  1'b0, 0, 0, 0, 0);
    run_perm(0,  1'b0, 0, 0, 0, 0);
    run_perm(9,  1'b1, 0, 0, 0, 0);
    run_perm(15, 1'b0, 0, 0, 0, 0);
    run_perm(2,  1'b0, 10, 5, 0, 0);
    run_perm(5,  1'b1, 0, 0, 0, 2 + 2 * T + C_SB + 10);
    run_perm(3,  1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      run_perm($urandom_range(0, 15), 1'($urandom_range(0, 1)), 0, 0, $urandom_range(0, 20), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
